// File: rtl/i2c_master.sv
// i2c_master: single-transfer open-drain I2C master (7-bit address, one byte write or read)
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wr_data,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic [7:0] rd_data
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] START = 4'd1;
    localparam logic [3:0] ADDR  = 4'd2;
    localparam logic [3:0] AACK  = 4'd3;
    localparam logic [3:0] WDATA = 4'd4;
    localparam logic [3:0] WACK  = 4'd5;
    localparam logic [3:0] RDATA = 4'd6;
    localparam logic [3:0] RNACK = 4'd7;
    localparam logic [3:0] STOP  = 4'd8;

    logic [3:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    q;
    logic [2:0]    bits;
    logic [7:0]    sh;
    logic [7:0]    wd;
    logic          rw_r;
    logic          tick;
    logic          sample;
    logic          slot_end;

    assign tick     = busy && cnt == CW'(CLK_DIV - 1);
    assign sample   = tick && q == 2'd2;
    assign slot_end = tick && q == 2'd3;

    // Line drive is a pure decode of state and quarter, so reset releases the bus immediately
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state)
            START: begin
                scl_oe = q[1];
                sda_oe = q != 2'd0;
            end
            ADDR, WDATA: begin
                scl_oe = !q[1];
                sda_oe = !sh[7];
            end
            AACK, WACK, RDATA, RNACK: scl_oe = !q[1];
            STOP: begin
                scl_oe = q == 2'd0;
                sda_oe = !q[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            q       <= 2'd0;
            bits    <= 3'd0;
            sh      <= 8'd0;
            wd      <= 8'd0;
            rw_r    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            nack    <= 1'b0;
            rd_data <= 8'd0;
        end else begin
            done <= 1'b0;
            cnt  <= (tick || !busy) ? '0 : cnt + 1'b1;
            if (tick) q <= q + 2'd1;
            // busy stays up through the done cycle so a start there is ignored
            if (done) busy <= 1'b0;
            case (state)
                IDLE: if (start && !busy) begin
                    busy  <= 1'b1;
                    nack  <= 1'b0;
                    sh    <= {addr, rw};
                    wd    <= wr_data;
                    rw_r  <= rw;
                    q     <= 2'd0;
                    state <= START;
                end
                START: if (slot_end) begin
                    bits  <= 3'd7;
                    state <= ADDR;
                end
                ADDR, WDATA: if (slot_end) begin
                    sh   <= {sh[6:0], 1'b0};
                    bits <= bits - 3'd1;
                    if (bits == 3'd0) state <= (state == ADDR) ? AACK : WACK;
                end
                AACK: begin
                    if (sample && sda_in) nack <= 1'b1;
                    if (slot_end) begin
                        sh    <= wd;
                        bits  <= 3'd7;
                        state <= nack ? STOP : rw_r ? RDATA : WDATA;
                    end
                end
                WACK: begin
                    if (sample && sda_in) nack <= 1'b1;
                    if (slot_end) state <= STOP;
                end
                RDATA: begin
                    if (sample) sh <= {sh[6:0], sda_in};
                    if (slot_end) begin
                        bits <= bits - 3'd1;
                        if (bits == 3'd0) state <= RNACK;
                    end
                end
                RNACK: if (slot_end) state <= STOP;
                STOP: if (slot_end) begin
                    done  <= 1'b1;
                    state <= IDLE;
                    if (rw_r) rd_data <= sh;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
